// File: rtl/kf76489_pkg.sv
// Shared definitions for the KF76489 PSG: register addresses, bus FSM states
// and the register-to-strobe decode used by the CPU write port.
package kf76489_pkg;

    localparam logic [2:0] REG_TONE0_FREQ = 3'd0;
    localparam logic [2:0] REG_TONE0_ATT  = 3'd1;
    localparam logic [2:0] REG_TONE1_FREQ = 3'd2;
    localparam logic [2:0] REG_TONE1_ATT  = 3'd3;
    localparam logic [2:0] REG_TONE2_FREQ = 3'd4;
    localparam logic [2:0] REG_TONE2_ATT  = 3'd5;
    localparam logic [2:0] REG_NOISE_CTRL = 3'd6;
    localparam logic [2:0] REG_NOISE_ATT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        STROBE,
        RELEASE
    } bus_state_t;

    typedef struct packed {
        logic [2:0] tone_frequency_low;
        logic [2:0] tone_frequency_high;
        logic [2:0] tone_attenuation;
        logic       noise_control;
        logic       noise_attenuation;
    } write_strobes_t;

    // Frequency registers split on byte type; every other register takes either byte.
    function automatic write_strobes_t decode_write(input logic [2:0] reg_addr,
                                                    input logic       latch_byte);
        write_strobes_t s;
        s = '0;
        case (reg_addr)
            REG_TONE0_FREQ: if (latch_byte) s.tone_frequency_low[0] = 1'b1;
                            else            s.tone_frequency_high[0] = 1'b1;
            REG_TONE1_FREQ: if (latch_byte) s.tone_frequency_low[1] = 1'b1;
                            else            s.tone_frequency_high[1] = 1'b1;
            REG_TONE2_FREQ: if (latch_byte) s.tone_frequency_low[2] = 1'b1;
                            else            s.tone_frequency_high[2] = 1'b1;
            REG_TONE0_ATT:  s.tone_attenuation[0] = 1'b1;
            REG_TONE1_ATT:  s.tone_attenuation[1] = 1'b1;
            REG_TONE2_ATT:  s.tone_attenuation[2] = 1'b1;
            REG_NOISE_CTRL: s.noise_control       = 1'b1;
            default:        s.noise_attenuation   = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kf76489_synchronizer.sv
// Two-flop synchroniser for an asynchronous active-low pin; idles high so a
// reset never looks like an asserted pin.
module kf76489_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // NOTE: non-blocking assignments keep both flops sampling the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/kf76489_bus_interface.sv
// KF76489 CPU write port: synchronises CE/WE, captures the byte, holds READY low
// for WAIT_TICKS chip-clock ticks, then issues one decoded write strobe.
module kf76489_bus_interface
    import kf76489_pkg::*;
#(
    parameter int WAIT_TICKS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_enable,
    input  logic       chip_enable_n,
    input  logic       write_enable_n,
    input  logic [7:0] data_bus,
    output logic       ready,
    output logic [7:0] internal_data_bus,
    output logic [2:0] write_tone_frequency_low,
    output logic [2:0] write_tone_frequency_high,
    output logic [2:0] write_tone_attenuation,
    output logic       write_noise_control,
    output logic       write_noise_attenuation
);

    localparam logic [7:0] LAST_TICK = 8'(WAIT_TICKS - 1);

    logic           chip_enable_sync_n;
    logic           write_enable_sync_n;
    logic           write_req;
    logic           last_tick;
    logic [7:0]     tick_count;
    logic [2:0]     latched_register;
    bus_state_t     state;
    bus_state_t     next_state;
    write_strobes_t strobes;

    kf76489_synchronizer u_chip_enable_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (chip_enable_n),
        .sync_out (chip_enable_sync_n)
    );

    kf76489_synchronizer u_write_enable_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (write_enable_n),
        .sync_out (write_enable_sync_n)
    );

    assign write_req = ~chip_enable_sync_n & ~write_enable_sync_n;
    assign last_tick = clock_enable && (tick_count == LAST_TICK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: defaulting next_state first keeps every path assigned, so no latch.
        next_state = state;
        case (state)
            IDLE:    if (write_req)  next_state = BUSY;
            BUSY:    if (last_tick)  next_state = STROBE;
            STROBE:                  next_state = RELEASE;
            RELEASE: if (!write_req) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Capture and latch update happen together, so the decode in STROBE sees
    // the register chosen by this very byte when it is a latch byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            internal_data_bus <= 8'h00;
            latched_register  <= 3'b000;
            tick_count        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_req) begin
                        internal_data_bus <= data_bus;
                        tick_count        <= 8'd0;
                        if (data_bus[0]) begin
                            latched_register <= {data_bus[1], data_bus[2], data_bus[3]};
                        end
                    end
                end
                BUSY: begin
                    if (clock_enable) tick_count <= tick_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready   = 1'b1;
        strobes = '0;
        case (state)
            BUSY:   ready = 1'b0;
            STROBE: begin
                ready   = 1'b0;
                strobes = decode_write(latched_register, internal_data_bus[0]);
            end
            default: ;
        endcase
    end

    assign write_tone_frequency_low  = strobes.tone_frequency_low;
    assign write_tone_frequency_high = strobes.tone_frequency_high;
    assign write_tone_attenuation    = strobes.tone_attenuation;
    assign write_noise_control       = strobes.noise_control;
    assign write_noise_attenuation   = strobes.noise_attenuation;

endmodule

// File: tb/tb_kf76489_bus_interface.sv
// Directed bench for the KF76489 write port: a scoreboard queue of expected
// strobes is filled as bytes are written and drained by a strobe monitor.
module tb_kf76489_bus_interface;

    localparam int WAIT_TICKS = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clock_enable = 1'b0;
    logic       chip_enable_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic [7:0] data_bus = 8'h00;
    logic       ready;
    logic [7:0] internal_data_bus;
    logic [2:0] write_tone_frequency_low;
    logic [2:0] write_tone_frequency_high;
    logic [2:0] write_tone_attenuation;
    logic       write_noise_control;
    logic       write_noise_attenuation;

    kf76489_bus_interface #(.WAIT_TICKS(WAIT_TICKS)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .clock_enable              (clock_enable),
        .chip_enable_n             (chip_enable_n),
        .write_enable_n            (write_enable_n),
        .data_bus                  (data_bus),
        .ready                     (ready),
        .internal_data_bus         (internal_data_bus),
        .write_tone_frequency_low  (write_tone_frequency_low),
        .write_tone_frequency_high (write_tone_frequency_high),
        .write_tone_attenuation    (write_tone_attenuation),
        .write_noise_control       (write_noise_control),
        .write_noise_attenuation   (write_noise_attenuation)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [18:0] exp_q[$];           // {captured byte, strobe vector}
    int          strobe_count = 0;
    int          low_len = 0;
    int          busy_ticks = 0;
    int          last_low_len = 0;
    int          last_busy_ticks = 0;
    logic [10:0] mon_vec;
    logic [10:0] last_vec = '0;
    logic [18:0] mon_entry;
    logic [2:0]  model_reg = 3'd0;
    bit          ce_pulse = 1'b0;
    bit          ce_level = 1'b1;
    int          ce_phase = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe vector layout: {freq_low[2:0], freq_high[2:0], attenuation[2:0], noise_ctrl, noise_att}
    function automatic logic [10:0] expected_strobe(input logic [2:0] r, input bit latch);
        logic [10:0] v;
        case (r)
            3'd0:    v = latch ? 11'b001_000_000_0_0 : 11'b000_001_000_0_0;
            3'd1:    v = 11'b000_000_001_0_0;
            3'd2:    v = latch ? 11'b010_000_000_0_0 : 11'b000_010_000_0_0;
            3'd3:    v = 11'b000_000_010_0_0;
            3'd4:    v = latch ? 11'b100_000_000_0_0 : 11'b000_100_000_0_0;
            3'd5:    v = 11'b000_000_100_0_0;
            3'd6:    v = 11'b000_000_000_1_0;
            default: v = 11'b000_000_000_0_1;
        endcase
        return v;
    endfunction

    task automatic push_expect(input logic [7:0] d);
        if (d[0]) model_reg = {d[1], d[2], d[3]};
        exp_q.push_back({d, expected_strobe(model_reg, d[0])});
    endtask

    // Drive one write, hold the pins low for `hold` cycles, change data_bus after
    // capture, and wait (bounded) for exactly one strobe.
    task automatic write_byte(input logic [7:0] d, input int hold, input int budget);
        int start;
        int n;
        start = strobe_count;
        n = 0;
        push_expect(d);
        @(posedge clock); #1;
        data_bus = d;
        chip_enable_n = 1'b0;
        write_enable_n = 1'b0;
        while ((n < hold || strobe_count == start) && n < budget) begin
            @(posedge clock); #1;
            n++;
            if (n == hold) begin
                chip_enable_n = 1'b1;
                write_enable_n = 1'b1;
            end
            if (n == 5) data_bus = ~d;
        end
        check($sformatf("strobes_for_%02h", d), strobe_count - start, 1);
        chip_enable_n = 1'b1;
        write_enable_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clock); #1;
            if (ce_pulse) begin
                clock_enable = (ce_phase == 0);
                ce_phase = (ce_phase + 1) % 16;
            end else begin
                clock_enable = ce_level;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                low_len = 0;
                busy_ticks = 0;
            end else begin
                mon_vec = {write_tone_frequency_low, write_tone_frequency_high,
                           write_tone_attenuation, write_noise_control, write_noise_attenuation};
                if (mon_vec != '0) begin
                    strobe_count++;
                    last_vec = mon_vec;
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'(mon_vec), 32'd0);
                    end else begin
                        mon_entry = exp_q.pop_front();
                        check("strobe_vector", 32'(mon_vec), 32'(mon_entry[10:0]));
                        check("strobe_data", 32'(internal_data_bus), 32'(mon_entry[18:11]));
                    end
                end
                if (!ready) begin
                    low_len++;
                    if (mon_vec == '0 && clock_enable) busy_ticks++;
                end else if (low_len != 0) begin
                    last_low_len = low_len;
                    last_busy_ticks = busy_ticks;
                    low_len = 0;
                    busy_ticks = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;

        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", ready, 1);
        check("reset_idb", internal_data_bus, 8'h00);
        check("reset_strobes", {write_tone_frequency_low, write_tone_frequency_high,
              write_tone_attenuation, write_noise_control, write_noise_attenuation}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Latch register 0, nibble 0
        write_byte(8'h01, 4, 100);
        check("ready_low_cycles", last_low_len, WAIT_TICKS + 1);
        check("busy_ticks", last_busy_ticks, WAIT_TICKS);
        check("idb_after_change", internal_data_bus, 8'h01);

        // Latch register 4 (tone 2 freq) then a data byte to its high bits
        write_byte(8'h03, 4, 100);
        write_byte(8'hFC, 4, 100);
        check("tone2_high_vec", last_vec, 11'b000_100_000_0_0);

        // Noise control with FB=1, then a data byte to the same register
        write_byte(8'h27, 4, 100);
        check("noise_fb_bit", internal_data_bus[5], 1'b1);
        write_byte(8'hC0, 4, 100);
        check("noise_ctrl_again", last_vec, 11'b000_000_000_1_0);

        // Attenuation registers and the remaining tone frequency
        write_byte(8'h09, 4, 100);
        write_byte(8'h0D, 4, 100);
        write_byte(8'h0B, 4, 100);
        write_byte(8'h0F, 4, 100);
        write_byte(8'h05, 4, 100);

        // Pins held low for 100 cycles: one strobe, ready back high while held
        write_byte(8'h90, 100, 200);
        write_byte(8'h01, 4, 100);

        // clock_enable pulsing every 16 cycles
        ce_pulse = 1'b1;
        write_byte(8'h50, 4, 800);
        check("pulse_busy_ticks", last_busy_ticks, WAIT_TICKS);
        check("pulse_low_in_range",
              (last_low_len >= 16 * (WAIT_TICKS - 1) + 2) &&
              (last_low_len <= 16 * WAIT_TICKS + 1), 1);
        ce_pulse = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // clock_enable stuck low: stays in BUSY, then completes once ticks resume
        ce_level = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        start = strobe_count;
        data_bus = 8'h01;
        chip_enable_n = 1'b0;
        write_enable_n = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        check("stuck_ready_low", ready, 0);
        check("stuck_no_strobe", strobe_count - start, 0);
        push_expect(8'h01);
        ce_level = 1'b1;
        n = 0;
        while (strobe_count == start && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        check("stuck_resume_strobe", strobe_count - start, 1);
        chip_enable_n = 1'b1;
        write_enable_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("stuck_busy_ticks", last_busy_ticks, WAIT_TICKS);

        // Reset at BUSY tick 10 after latching register 4
        write_byte(8'h03, 4, 100);
        start = strobe_count;
        data_bus = 8'h0F;
        chip_enable_n = 1'b0;
        write_enable_n = 1'b0;
        n = 0;
        while (ready && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("abort_entered_busy", ready, 0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ready", ready, 1);
        check("abort_strobes", {write_tone_frequency_low, write_tone_frequency_high,
              write_tone_attenuation, write_noise_control, write_noise_attenuation}, 0);
        chip_enable_n = 1'b1;
        write_enable_n = 1'b1;
        model_reg = 3'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        check("abort_no_strobe", strobe_count - start, 0);
        write_byte(8'hFC, 4, 100);
        check("post_reset_target", last_vec, 11'b000_001_000_0_0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
